// File: rtl/phase_sweep_if.sv
// Board-control / waveform-side signal bundle for the phase sweep sequencer.
// master drives the control inputs, slave is the sequencer itself.
interface phase_sweep_if #(
   parameter int SIZE_VALUE = 7,
   parameter int PHASE_W    = 16,
   parameter int DWELL_W    = 16
);
   logic                         i_en;
   logic                         i_start;
   logic                         i_abort;
   logic        [SIZE_VALUE-1:0] i_step_inc;
   logic        [SIZE_VALUE-1:0] i_step_lim;
   logic        [DWELL_W-1:0]    i_dwell;
   logic signed [SIZE_VALUE:0]   o_step;
   logic        [PHASE_W-1:0]    o_phase;
   logic                         o_busy;
   logic                         o_done;
   logic        [2:0]            o_state;

   modport master (
      output i_en, i_start, i_abort, i_step_inc, i_step_lim, i_dwell,
      input  o_step, o_phase, o_busy, o_done, o_state
   );

   modport slave (
      input  i_en, i_start, i_abort, i_step_inc, i_step_lim, i_dwell,
      output o_step, o_phase, o_busy, o_done, o_state
   );
endinterface

// File: rtl/phase_sweep_ctrl.sv
// Phase sweep sequencer: ramps a signed step 0 -> +lim -> -lim -> 0 and integrates it into a phase.
// Optional PHASE_SWEEP_LOOP_EN: on reaching 0 from RETURN, pulse done and restart UP until aborted.
module phase_sweep_ctrl #(
   parameter int SIZE_VALUE = 7,
   parameter int PHASE_W    = 16,
   parameter int DWELL_W    = 16
) (
   input logic          i_clk,
   input logic          i_rst_n,
   phase_sweep_if.slave bus
);

   localparam int STEP_W  = SIZE_VALUE + 1;
   localparam int ARITH_W = SIZE_VALUE + 2;

   localparam logic [DWELL_W-1:0]    CNT_ZERO  = {DWELL_W{1'b0}};
   localparam logic [DWELL_W-1:0]    DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
   localparam logic [SIZE_VALUE-1:0] MAG_ZERO  = {SIZE_VALUE{1'b0}};
   localparam logic [SIZE_VALUE-1:0] INC_ONE   = {{(SIZE_VALUE-1){1'b0}}, 1'b1};
   localparam logic [STEP_W-1:0]     STEP_ZERO = {STEP_W{1'b0}};
   localparam logic [PHASE_W-1:0]    PH_ZERO   = {PHASE_W{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UP     = 3'd1,
      ST_HOLD   = 3'd2,
      ST_DOWN   = 3'd3,
      ST_RETURN = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   function automatic logic [PHASE_W-1:0] sext_step(input logic [STEP_W-1:0] s);
      sext_step = {{(PHASE_W-STEP_W){s[STEP_W-1]}}, s};
   endfunction

   state_t                    state_r;
   state_t                    state_s;
   logic        [STEP_W-1:0]  step_r;
   logic        [STEP_W-1:0]  step_s;
   logic        [DWELL_W-1:0] cnt_r;
   logic        [DWELL_W-1:0] cnt_s;
   logic                      done_r;
   logic                      done_s;
   logic                      latch_s;
   logic        [PHASE_W-1:0] phase_r;

   logic        [SIZE_VALUE-1:0] inc_r;
   logic        [SIZE_VALUE-1:0] lim_r;
   logic        [DWELL_W-1:0]    dwell_r;

   logic        [SIZE_VALUE-1:0] inc_eff_s;
   logic        [DWELL_W-1:0]    dwell_eff_s;
   logic signed [ARITH_W-1:0]    step_x_s;
   logic signed [ARITH_W-1:0]    inc_x_s;
   logic signed [ARITH_W-1:0]    lim_x_s;
   logic signed [ARITH_W-1:0]    neg_lim_s;
   logic signed [ARITH_W-1:0]    up_sum_s;
   logic signed [ARITH_W-1:0]    dn_diff_s;
   logic                         tick_s;

   // Sanitised operands and one-bit-wider arithmetic so the clamps never overflow
   always_comb begin
      inc_eff_s   = (inc_r == MAG_ZERO) ? INC_ONE : inc_r;
      dwell_eff_s = (dwell_r == CNT_ZERO) ? DWELL_ONE : dwell_r;
      step_x_s    = {step_r[STEP_W-1], step_r};
      inc_x_s     = {2'b00, inc_eff_s};
      lim_x_s     = {2'b00, lim_r};
      neg_lim_s   = -lim_x_s;
      up_sum_s    = step_x_s + inc_x_s;
      dn_diff_s   = step_x_s - inc_x_s;
      tick_s      = bus.i_en && (cnt_r == (dwell_eff_s - DWELL_ONE));
   end

   // Next-state, next-step and dwell counter; abort overrides everything
   always_comb begin
      state_s = state_r;
      step_s  = step_r;
      cnt_s   = cnt_r;
      done_s  = 1'b0;
      latch_s = 1'b0;
      if (bus.i_abort) begin
         state_s = ST_IDLE;
         step_s  = STEP_ZERO;
         cnt_s   = CNT_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.i_start) begin
                  latch_s = 1'b1;
                  step_s  = STEP_ZERO;
                  cnt_s   = CNT_ZERO;
                  if (bus.i_step_lim == MAG_ZERO) begin
                     state_s = ST_DONE;
                     done_s  = 1'b1;
                  end else begin
                     state_s = ST_UP;
                  end
               end else begin
                  step_s = STEP_ZERO;
                  cnt_s  = CNT_ZERO;
               end
            end
            ST_UP, ST_HOLD, ST_DOWN, ST_RETURN: begin
               if (!bus.i_en) begin
                  cnt_s = cnt_r;
               end else if (!tick_s) begin
                  cnt_s = cnt_r + DWELL_ONE;
               end else begin
                  cnt_s = CNT_ZERO;
                  case (state_r)
                     ST_UP: begin
                        if (up_sum_s >= lim_x_s) begin
                           step_s  = lim_x_s[STEP_W-1:0];
                           state_s = ST_HOLD;
                        end else begin
                           step_s = up_sum_s[STEP_W-1:0];
                        end
                     end
                     ST_HOLD: begin
                        state_s = ST_DOWN;
                     end
                     ST_DOWN: begin
                        if (dn_diff_s <= neg_lim_s) begin
                           step_s  = neg_lim_s[STEP_W-1:0];
                           state_s = ST_RETURN;
                        end else begin
                           step_s = dn_diff_s[STEP_W-1:0];
                        end
                     end
                     ST_RETURN: begin
                        if (up_sum_s[ARITH_W-1] == 1'b0) begin
                           step_s = STEP_ZERO;
                           done_s = 1'b1;
`ifdef PHASE_SWEEP_LOOP_EN
                           state_s = ST_UP;
`else
                           state_s = ST_DONE;
`endif
                        end else begin
                           step_s = up_sum_s[STEP_W-1:0];
                        end
                     end
                     default: begin
                        state_s = ST_IDLE;
                     end
                  endcase
               end
            end
            ST_DONE: begin
               state_s = ST_IDLE;
               step_s  = STEP_ZERO;
               cnt_s   = CNT_ZERO;
            end
            default: begin
               state_s = ST_IDLE;
               step_s  = STEP_ZERO;
               cnt_s   = CNT_ZERO;
            end
         endcase
      end
   end

   // Control state, current step, dwell counter and completion pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         step_r  <= STEP_ZERO;
         cnt_r   <= CNT_ZERO;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         step_r  <= step_s;
         cnt_r   <= cnt_s;
         done_r  <= done_s;
      end
   end

   // Sweep operands are captured only at start so mid-sweep input changes are ignored
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         inc_r   <= MAG_ZERO;
         lim_r   <= MAG_ZERO;
         dwell_r <= CNT_ZERO;
      end else if (latch_s) begin
         inc_r   <= bus.i_step_inc;
         lim_r   <= bus.i_step_lim;
         dwell_r <= bus.i_dwell;
      end
   end

   // Wrapping phase integrator fed by the registered step
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phase_r <= PH_ZERO;
      end else if (bus.i_en) begin
         phase_r <= phase_r + sext_step(step_r);
      end
   end

   assign bus.o_step  = step_r;
   assign bus.o_phase = phase_r;
   assign bus.o_done  = done_r;
   assign bus.o_state = state_r;
   assign bus.o_busy  = (state_r == ST_UP) || (state_r == ST_HOLD) ||
                        (state_r == ST_DOWN) || (state_r == ST_RETURN);

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Directed scoreboard bench for phase_sweep_ctrl (default single-shot build).
module tb_phase_sweep_ctrl;

   localparam int S_IDLE = 0, S_UP = 1, S_HOLD = 2, S_DOWN = 3, S_RET = 4, S_DONE = 5;

   typedef struct {
      logic signed [7:0] step;
      logic [2:0]        state;
      logic              busy;
      logic              done;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   exp_t        exp_q[$];
   int          n_pass, n_fail, n_total;
   logic [15:0] ph_model;

   phase_sweep_if #(.SIZE_VALUE(7), .PHASE_W(16), .DWELL_W(16)) bus ();

   phase_sweep_ctrl #(.SIZE_VALUE(7), .PHASE_W(16), .DWELL_W(16)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input int step, input int st, input bit busy, input bit done);
      exp_t e;
      e.step  = step[7:0];
      e.state = st[2:0];
      e.busy  = busy;
      e.done  = done;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_entry(input exp_t e, input string tag);
      chk({tag, ".step"},  {24'd0, bus.o_step},  {24'd0, e.step});
      chk({tag, ".state"}, {29'd0, bus.o_state}, {29'd0, e.state});
      chk({tag, ".busy"},  {31'd0, bus.o_busy},  {31'd0, e.busy});
      chk({tag, ".done"},  {31'd0, bus.o_done},  {31'd0, e.done});
      chk({tag, ".phase"}, {16'd0, bus.o_phase}, {16'd0, ph_model});
   endtask

   task automatic push_n(input int v, input int st, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(mk(v, st, 1'b1, 1'b0));
   endtask

   // Reference sweep: one entry per enabled cycle, each step value lasting one dwell
   task automatic push_sweep(input int inc, input int lim, input int dwell);
      int v, ie, de;
      ie = (inc == 0) ? 1 : inc;
      de = (dwell == 0) ? 1 : dwell;
      v  = 0;
      if (lim != 0) begin
         while (v < lim) begin
            push_n(v, S_UP, de);
            v = (v + ie > lim) ? lim : v + ie;
         end
         push_n(v, S_HOLD, de);
         while (v > -lim) begin
            push_n(v, S_DOWN, de);
            v = (v - ie < -lim) ? -lim : v - ie;
         end
         while (v < 0) begin
            push_n(v, S_RET, de);
            v = (v + ie > 0) ? 0 : v + ie;
         end
      end
      exp_q.push_back(mk(0, S_DONE, 1'b0, 1'b1));
      exp_q.push_back(mk(0, S_IDLE, 1'b0, 1'b0));
   endtask

   task automatic do_start(input int inc, input int lim, input int dwell, input bit with_abort);
      bus.i_step_inc = inc[6:0];
      bus.i_step_lim = lim[6:0];
      bus.i_dwell    = dwell[15:0];
      bus.i_start    = 1'b1;
      bus.i_abort    = with_abort;
      bus.i_en       = 1'b1;
      if (with_abort) begin
         exp_q.push_back(mk(0, S_IDLE, 1'b0, 1'b0));
         exp_q.push_back(mk(0, S_IDLE, 1'b0, 1'b0));
      end else begin
         push_sweep(inc, lim, dwell);
      end
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
   endtask

   task automatic run_sweep(input bit gate, input int start_at, input int abort_at, input string tag);
      exp_t e;
      bit   en;
      int   cyc;
      en  = 1'b0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 200) begin
         e = exp_q[0];
         check_entry(e, tag);
         en          = gate ? ~en : 1'b1;
         bus.i_en    = en;
         bus.i_start = (cyc == start_at);
         bus.i_abort = (cyc == abort_at);
         if (cyc == start_at) bus.i_step_lim = 7'd0;
         if (en) ph_model = ph_model + {{8{e.step[7]}}, e.step};
         @(posedge clk); #1;
         bus.i_start = 1'b0;
         bus.i_abort = 1'b0;
         if (cyc == abort_at) begin
            exp_q.delete();
            exp_q.push_back(mk(0, S_IDLE, 1'b0, 1'b0));
            exp_q.push_back(mk(0, S_IDLE, 1'b0, 1'b0));
         end else if (en || !e.busy) begin
            void'(exp_q.pop_front());
         end
         cyc++;
      end
      if (exp_q.size() != 0) begin
         n_total++;
         n_fail++;
         $error("FAIL %s.timeout: observed %0d pending expected 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      int k;
      int st;
      n_pass = 0; n_fail = 0; n_total = 0;
      ph_model       = 16'h0000;
      bus.i_en       = 1'b0;
      bus.i_start    = 1'b0;
      bus.i_abort    = 1'b0;
      bus.i_step_inc = 7'd0;
      bus.i_step_lim = 7'd0;
      bus.i_dwell    = 16'd0;

      repeat (2) @(posedge clk);
      #1;
      check_entry(mk(0, S_IDLE, 1'b0, 1'b0), "reset");
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check_entry(mk(0, S_IDLE, 1'b0, 1'b0), "post_reset");

      // Basic sweep with an ignored start (lim=0) in the middle
      do_start(1, 3, 2, 1'b0);
      run_sweep(1'b0, 5, -1, "basic");
      do_start(5, 3, 1, 1'b0);
      run_sweep(1'b0, -1, -1, "clamp");
      do_start(3, 0, 4, 1'b0);
      run_sweep(1'b0, -1, -1, "lim0");
      do_start(0, 2, 0, 1'b0);
      run_sweep(1'b0, -1, -1, "sanitise");
      do_start(1, 3, 2, 1'b0);
      run_sweep(1'b1, -1, -1, "gated");
      // Entry 16 of the basic sweep is the first DOWN cycle at step -1
      do_start(1, 3, 2, 1'b0);
      run_sweep(1'b0, -1, 16, "abort");
      do_start(1, 3, 2, 1'b1);
      run_sweep(1'b0, -1, -1, "start_abort");

      // Asynchronous reset in the middle of UP clears everything without a clock edge
      do_start(1, 3, 2, 1'b0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset.step", {24'd0, bus.o_step}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      ph_model = 16'h0000;
      check_entry(mk(0, S_IDLE, 1'b0, 1'b0), "async_reset");
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check_entry(mk(0, S_IDLE, 1'b0, 1'b0), "after_reset");

      // Phase wrap: step 0 for 13108, 2 for 13108, then +3 reaches 0xFFFE in HOLD
      bus.i_step_inc = 7'd2;
      bus.i_step_lim = 7'd3;
      bus.i_dwell    = 16'd13108;
      bus.i_en       = 1'b1;
      bus.i_start    = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      k = 0;
      while (ph_model != 16'hFFFE && k < 60000) begin
         st = (k < 13108) ? 0 : ((k < 26216) ? 2 : 3);
         ph_model = ph_model + st[15:0];
         @(posedge clk); #1;
         k++;
      end
      chk("wrap.pre_phase", {16'd0, bus.o_phase}, 32'h0000_FFFE);
      chk("wrap.pre_step",  {24'd0, bus.o_step},  32'd3);
      chk("wrap.pre_state", {29'd0, bus.o_state}, 32'd2);
      @(posedge clk); #1;
      chk("wrap.post_phase", {16'd0, bus.o_phase}, 32'h0000_0001);
      ph_model    = 16'h0004;
      bus.i_abort = 1'b1;
      @(posedge clk); #1;
      bus.i_abort = 1'b0;
      check_entry(mk(0, S_IDLE, 1'b0, 1'b0), "wrap_abort");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/phase_sweep_ctrl.md
Name: phase_sweep_ctrl

Overview:
Sequencer that drives the signed phase-step of the DSP phase accumulator automatically instead of by button.
- On start, ramps the step from 0 up to +limit, holds, ramps down to −limit, then returns to 0. Each step change is spaced by a programmable dwell period.
- Integrates the current step into a wrapping phase accumulator, which feeds the waveform lookup datapath.
- Sits between the board control inputs (switches/buttons, already edge-detected) and the waveform generator.

Parameters:
- SIZE_VALUE, 7, step magnitude width; o_step is SIZE_VALUE+1 bits signed.
- PHASE_W, 16, phase accumulator width.
- DWELL_W, 16, dwell counter width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  clock enable; gates dwell counting and phase accumulation
- i_start  in  1  single-cycle start pulse
- i_abort  in  1  single-cycle abort pulse
- i_step_inc  in  SIZE_VALUE  unsigned step increment per dwell period
- i_step_lim  in  SIZE_VALUE  unsigned step magnitude limit
- i_dwell  in  DWELL_W  enabled cycles per step update
- o_step  out  SIZE_VALUE+1  signed current step
- o_phase  out  PHASE_W  phase accumulator
- o_busy  out  1  high in UP/HOLD/DOWN/RETURN
- o_done  out  1  one-cycle pulse on completed sweep
- o_state  out  3  state encoding

Behaviour:
- Reset (async):
  - state=IDLE, o_step=0, o_phase=0, o_done=0, dwell counter=0.
  - Latched inc/lim/dwell are cleared to 0.
- State encodings: IDLE=0, UP=1, HOLD=2, DOWN=3, RETURN=4, DONE=5. Codes 6 and 7 recover to IDLE on the next cycle.
- IDLE:
  - i_start=1 and i_abort=0: latch inc, lim and dwell; set step=0 and counter=0.
  - If latched lim==0, go to DONE; otherwise go to UP.
  - i_start is ignored in every state other than IDLE.
- Operand sanitising: latched inc==0 is treated as 1; latched dwell==0 is treated as 1.
- Dwell timing:
  - In UP/HOLD/DOWN/RETURN, the counter increments only on cycles with i_en=1.
  - When counter==dwell−1 with i_en=1, this is a "tick": the counter clears and the step/state update below is applied in that same cycle.
  - With i_en=0, counter, step and state all hold.
- Per-tick updates (arithmetic done in SIZE_VALUE+2 bits, so no overflow):
  - UP: step=min(step+inc, +lim); go to HOLD when the new step equals +lim.
  - HOLD: step unchanged; go to DOWN.
  - DOWN: step=max(step−inc, −lim); go to RETURN when the new step equals −lim.
  - RETURN: step=min(step+inc, 0); go to DONE when the new step equals 0.
- DONE: o_done=1 for exactly one cycle, step=0, then IDLE.
- Phase accumulator:
  - Every cycle with i_en=1, in any state: o_phase = o_phase + sign-extended o_step, modulo 2^PHASE_W.
  - Uses the registered o_step, so a step change affects the phase one cycle later.
  - Accumulation continues in IDLE with step=0, i.e. the phase holds.
- Abort:
  - i_abort=1 in any state forces IDLE next cycle with step=0 and counter=0.
  - No o_done pulse; o_phase is kept.
  - Abort wins over a simultaneous start, tick or DONE.
- Input stability: inputs are sampled only at start; changes mid-sweep have no effect.
- o_busy and o_state are registered-state decodes.

Optional Feature:
PHASE_SWEEP_LOOP_EN:
- Defined: RETURN reaching 0 pulses o_done for one cycle and re-enters UP directly, skipping DONE and IDLE. The counter is cleared and sweeping repeats until i_abort. o_busy stays high throughout.
- Undefined: single-shot behaviour as above.

Test Plan:
- Basic sweep: inc=1, lim=3, dwell=2, i_en=1, start → o_step sequence 0,1,2,3,3(HOLD),2,1,0,−1,−2,−3,−2,−1,0, each value held for 2 cycles. 26 cycles busy; o_done in cycle 27 after start; then IDLE.
- Clamping: inc=5, lim=3, dwell=1 → o_step sequence 0,3,3,−2,−3,0, then DONE. Also lim=0 → DONE on the next cycle with o_busy never high.
- Enable gating: same as the basic sweep but i_en toggled 1/0 → each step value lasts 4 cycles. o_phase is unchanged on i_en=0 cycles.
- Phase wrap: PHASE_W=16, preload by running step=+3 until o_phase=0xFFFE → next enabled cycle gives o_phase=0x0001.
- Abort and ignored start:
  - Abort in DOWN at step=−1 → IDLE next cycle, step=0, no o_done.
  - A start issued mid-sweep is ignored.
  - Simultaneous start+abort in IDLE → stays IDLE.
- Reset and loop:
  - Async reset asserted mid-UP → all outputs 0 immediately.
  - With PHASE_SWEEP_LOOP_EN, the basic-sweep config produces o_done every 26 cycles and UP re-entered, until abort.
